// File: rtl/apb_node_pkg.sv
// Shared types and defaults for the registered APB 1-to-N node.
package apb_node_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        ERR,
        RESP
    } apb_node_state_e;

    // Index width for n slaves; a single slave still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned IDX_W = idx_width(9);

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hBADA_BADA;

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational start/end range decoder; the lowest matching index wins.
module apb_addr_decoder
    import apb_node_pkg::*;
#(
    parameter int unsigned NB_SLAVE = 9,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned IDX_BITS = IDX_W
) (
    input  logic [ADDR_W-1:0]          addr,
    input  logic [NB_SLAVE*ADDR_W-1:0] start_addr,
    input  logic [NB_SLAVE*ADDR_W-1:0] end_addr,
    output logic                       hit,
    output logic [IDX_BITS-1:0]        idx
);

    // Scan from the highest index down so the lowest hit overwrites last.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NB_SLAVE - 1; i >= 0; i--) begin
            if ((addr >= start_addr[i*ADDR_W +: ADDR_W]) &&
                (addr <= end_addr[i*ADDR_W +: ADDR_W])) begin
                hit = 1'b1;
                idx = IDX_BITS'(i);
            end
        end
    end

endmodule

// File: rtl/apb_node_reg.sv
// Registered APB 1-to-N node with run-time programmable address map.
// Optional slave-hang timeout: define APB_NODE_TIMEOUT_EN.
module apb_node_reg
    import apb_node_pkg::*;
#(
    parameter int unsigned NB_SLAVE       = 9,
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NB_SLAVE*APB_ADDR_WIDTH-1:0] start_addr_i,
    input  logic [NB_SLAVE*APB_ADDR_WIDTH-1:0] end_addr_i,
    input  logic [APB_ADDR_WIDTH-1:0]          m_paddr_i,
    input  logic [APB_DATA_WIDTH-1:0]          m_pwdata_i,
    input  logic                               m_pwrite_i,
    input  logic                               m_psel_i,
    input  logic                               m_penable_i,
    output logic [APB_DATA_WIDTH-1:0]          m_prdata_o,
    output logic                               m_pready_o,
    output logic                               m_pslverr_o,
    output logic [APB_ADDR_WIDTH-1:0]          s_paddr_o,
    output logic [APB_DATA_WIDTH-1:0]          s_pwdata_o,
    output logic                               s_pwrite_o,
    output logic [NB_SLAVE-1:0]                s_psel_o,
    output logic                               s_penable_o,
    input  logic [NB_SLAVE*APB_DATA_WIDTH-1:0] s_prdata_i,
    input  logic [NB_SLAVE-1:0]                s_pready_i,
    input  logic [NB_SLAVE-1:0]                s_pslverr_i
);

    localparam int unsigned IDX_BITS = idx_width(NB_SLAVE);
    localparam logic [APB_DATA_WIDTH-1:0] ERR_WORD = APB_DATA_WIDTH'(ERR_DATA);

    apb_node_state_e state, next_state;

    logic                      dec_hit;
    logic [IDX_BITS-1:0]       dec_idx;
    logic [IDX_BITS-1:0]       idx_q;
    logic [IDX_BITS-1:0]       idx_sel;
    logic                      accept;
    logic                      slv_ready;
    logic                      slv_err;
    logic [APB_DATA_WIDTH-1:0] slv_rdata;
    logic                      timeout;

    logic [NB_SLAVE-1:0]       s_psel_d;
    logic                      s_penable_d;
    logic                      m_pready_d;
    logic                      m_pslverr_d;
    logic [APB_DATA_WIDTH-1:0] m_prdata_d;

    apb_addr_decoder #(
        .NB_SLAVE (NB_SLAVE),
        .ADDR_W   (APB_ADDR_WIDTH),
        .IDX_BITS (IDX_BITS)
    ) u_dec (
        .addr       (m_paddr_i),
        .start_addr (start_addr_i),
        .end_addr   (end_addr_i),
        .hit        (dec_hit),
        .idx        (dec_idx)
    );

    assign accept  = m_psel_i & ~m_penable_i;
    assign idx_sel = (state == IDLE) ? dec_idx : idx_q;

    // Select the response of the slave owning the current transfer.
    always_comb begin
        slv_ready = 1'b0;
        slv_err   = 1'b0;
        slv_rdata = '0;
        for (int i = 0; i < NB_SLAVE; i++) begin
            if (idx_q == IDX_BITS'(i)) begin
                slv_ready = s_pready_i[i];
                slv_err   = s_pslverr_i[i];
                slv_rdata = s_prdata_i[i*APB_DATA_WIDTH +: APB_DATA_WIDTH];
            end
        end
    end

`ifdef APB_NODE_TIMEOUT_EN
    localparam int unsigned CNT_RAW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int unsigned CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);

    logic [CNT_W-1:0] to_cnt;

    // Count ACCESS cycles of the current transfer, restarting at SETUP entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            to_cnt <= '0;
        end else if (next_state == SETUP) begin
            to_cnt <= '0;
        end else if (state == ACCESS) begin
            to_cnt <= to_cnt + CNT_W'(1);
        end
    end

    // Last permitted ACCESS cycle; a ready slave in this cycle still wins.
    assign timeout = (state == ACCESS) && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // Without the timeout the parameter has no effect.
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; master inputs are only looked at in IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = dec_hit ? SETUP : ERR;
            SETUP:   next_state = ACCESS;
            ACCESS:  begin
                if (slv_ready)    next_state = RESP;
                else if (timeout) next_state = ERR;
            end
            ERR:     next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Next values of the registered bus outputs, derived from the coming state.
    always_comb begin
        s_psel_d    = '0;
        s_penable_d = 1'b0;
        m_pready_d  = 1'b0;
        m_pslverr_d = 1'b0;
        m_prdata_d  = '0;
        if ((next_state == SETUP) || (next_state == ACCESS)) begin
            s_psel_d = NB_SLAVE'(1) << idx_sel;
        end
        s_penable_d = (next_state == ACCESS);
        if (next_state == RESP) begin
            m_pready_d = 1'b1;
            if (state == ERR) begin
                m_pslverr_d = 1'b1;
                m_prdata_d  = ERR_WORD;
            end else begin
                m_pslverr_d = slv_err;
                m_prdata_d  = s_pwrite_o ? '0 : slv_rdata;
            end
        end
    end

    // Output registers and request capture; shared slave bus holds while idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s_psel_o    <= '0;
            s_penable_o <= 1'b0;
            m_pready_o  <= 1'b0;
            m_pslverr_o <= 1'b0;
            m_prdata_o  <= '0;
            s_paddr_o   <= '0;
            s_pwdata_o  <= '0;
            s_pwrite_o  <= 1'b0;
            idx_q       <= '0;
        end else begin
            s_psel_o    <= s_psel_d;
            s_penable_o <= s_penable_d;
            m_pready_o  <= m_pready_d;
            m_pslverr_o <= m_pslverr_d;
            m_prdata_o  <= m_prdata_d;
            if ((state == IDLE) && accept) begin
                s_paddr_o  <= m_paddr_i;
                s_pwdata_o <= m_pwdata_i;
                s_pwrite_o <= m_pwrite_i;
                idx_q      <= dec_idx;
            end
        end
    end

endmodule

// File: doc/apb_node_reg.md
Name: apb_node_reg

Overview:
- Parametrised, registered APB 1-to-N node for the SoC peripheral bus; successor to the fixed 9-slave APB address map.
- Decodes the master address against a run-time-programmable start/end map, which lets the map be reconfigured without editing RTL.
- Forwards each transfer to exactly one slave port, registering both the request and the response.
- Returns PSLVERR with error data for unmapped addresses and, when enabled, for slaves that hang.

Parameters:
NB_SLAVE, 9, number of slave ports (1..32)
APB_ADDR_WIDTH, 32, address width
APB_DATA_WIDTH, 32, data width
ERR_DATA, 32'hBADA_BADA, PRDATA value returned on any node-generated error (truncated to APB_DATA_WIDTH)
TIMEOUT_CYCLES, 256, maximum slave ACCESS cycles before abort (>=2; used only with the optional feature)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
start_addr_i  in  NB_SLAVE*APB_ADDR_WIDTH  per-slave inclusive start address, slice i = slave i
end_addr_i  in  NB_SLAVE*APB_ADDR_WIDTH  per-slave inclusive end address
m_paddr_i  in  APB_ADDR_WIDTH  master address
m_pwdata_i  in  APB_DATA_WIDTH  master write data
m_pwrite_i  in  1  master write
m_psel_i  in  1  master select
m_penable_i  in  1  master enable
m_prdata_o  out  APB_DATA_WIDTH  read data to master
m_pready_o  out  1  ready to master
m_pslverr_o  out  1  error to master
s_paddr_o  out  APB_ADDR_WIDTH  shared slave address
s_pwdata_o  out  APB_DATA_WIDTH  shared slave write data
s_pwrite_o  out  1  shared slave write
s_psel_o  out  NB_SLAVE  one-hot slave select
s_penable_o  out  1  shared slave enable
s_prdata_i  in  NB_SLAVE*APB_DATA_WIDTH  slave read data
s_pready_i  in  NB_SLAVE  slave ready
s_pslverr_i  in  NB_SLAVE  slave error

Behaviour:
- Reset (rst_ni low, asynchronous): state IDLE. All outputs 0: s_psel_o, s_penable_o, s_paddr_o, s_pwdata_o, s_pwrite_o, m_pready_o, m_pslverr_o, m_prdata_o. Index and timeout registers cleared.
- Decode: slave i hits when start_i <= addr <= end_i, unsigned compare. On overlapping ranges the lowest index wins. No hit means unmapped.
- IDLE:
  - On m_psel_i=1 and m_penable_i=0, capture paddr/pwdata/pwrite and the decoded index.
  - If a slave hits, go to SETUP. If unmapped, go to ERR.
- SETUP (1 cycle): s_psel_o[idx]=1, s_penable_o=0, then go to ACCESS.
- ACCESS:
  - s_psel_o[idx]=1 and s_penable_o=1; remain here while s_pready_i[idx]=0.
  - On s_pready_i[idx]=1, register s_prdata_i[idx] and s_pslverr_i[idx], drop s_psel_o and s_penable_o, then go to RESP.
- ERR (1 cycle): load m_prdata=ERR_DATA and m_pslverr=1, then go to RESP.
- RESP (1 cycle):
  - m_pready_o=1 with the registered prdata/pslverr; go to IDLE.
  - m_prdata_o is zero for writes, except ERR_DATA on node-generated errors.
  - m_pready_o, m_pslverr_o and m_prdata_o return to 0 the next cycle.
- Latency:
  - Master SETUP at cycle 0; zero-wait slave responds at cycle 2; m_pready_o=1 at cycle 3.
  - Each slave wait state adds 1 cycle.
  - Unmapped transfer: m_pready_o=1 at cycle 2.
- Master obligations: the master holds psel/penable/address until m_pready_o. The node ignores master inputs outside IDLE. Back-to-back transfers are accepted in the cycle after RESP.
- m_psel_i dropped mid-transfer: the node still completes the slave transfer and discards the response. Compliant masters never do this.
- Shared s_paddr_o/s_pwdata_o/s_pwrite_o hold their last captured values while idle.
- Map inputs are sampled only in IDLE. Changes during a transfer do not affect it.

Optional Feature:
- Macro: APB_NODE_TIMEOUT_EN
- Defined:
  - An 8..32-bit counter (clog2(TIMEOUT_CYCLES)+1 bits) clears on SETUP entry and increments each ACCESS cycle.
  - If it reaches TIMEOUT_CYCLES with s_pready_i[idx] still 0, drop s_psel_o/s_penable_o and go to ERR, which returns ERR_DATA with pslverr=1.
  - If s_pready_i arrives in the same cycle the counter reaches TIMEOUT_CYCLES, the slave response wins.
- Undefined: no counter; ACCESS waits indefinitely.

Decomposition:
- Package apb_node_pkg:
  - state enum apb_node_state_e {IDLE, SETUP, ACCESS, ERR, RESP};
  - localparam IDX_W = clog2(NB_SLAVE) default helper;
  - default ERR_DATA constant.
- Sub-module apb_addr_decoder: combinational, with parametrised priority match returning hit and index. The FSM, capture registers and timeout stay in apb_node_reg.

Test Plan:
- Read of 0x4A10_1004 with map slave1 = 0x4A10_1000..0x4A10_1FFF and slave1 zero-wait returning 0x1234_5678 -> s_psel_o=9'b000000010 at cycle 1, s_penable_o at cycle 2, m_pready_o=1 with m_prdata_o=0x1234_5678 and m_pslverr_o=0 at cycle 3.
- Write of 0xCAFE_F00D to slave 8 with 3 wait states -> s_pwdata_o=0xCAFE_F00D and s_pwrite_o=1; m_pready_o at cycle 6; m_prdata_o=0.
- Access to unmapped 0x5000_0000 -> no s_psel_o bit ever set; m_pready_o=1, m_pslverr_o=1, m_prdata_o=0xBADA_BADA at cycle 2.
- Overlapping map where slaves 2 and 5 both cover 0x4A10_2000; slave error asserted -> only s_psel_o[2] asserts; the slave's pslverr=1 propagates to m_pslverr_o.
- With APB_NODE_TIMEOUT_EN and TIMEOUT_CYCLES=4, slave never readies -> psel drops after 4 ACCESS cycles; m_pslverr_o=1 with ERR_DATA. Repeat with pready arriving exactly at count 4 -> slave data is returned with no error.
- Assert rst_ni low during ACCESS -> all outputs 0 immediately (asynchronously); after release, a new transfer completes normally.
